ir_fetch_seq: RTL
=================

Name: ir_fetch_seq

Overview:
- Instruction-fetch sequencer sitting directly upstream of the 16-bit instruction register (IR).
- On a start request it reads two consecutive bytes from byte-wide memory at the program counter (PC), low byte first, then high byte.
- It steers each byte into the IR through the IR's half-load interface: funsel, enable, L'/H select and 8-bit half input.
- It owns the PC, advancing it once per byte, and pulses done when the full instruction is present in the IR.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- RESET_PC, 0, PC value after reset.
- MEM_LAT, 1, cycles from the mem_rd cycle to mem_data valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  fetch request; sampled only in IDLE.
- pc_load  in  1  load PC from pc_in; honoured only in IDLE.
- pc_in  in  ADDR_W  new PC value.
- mem_data  in  8  byte returned by memory.
- mem_addr  out  ADDR_W  memory address; equals PC.
- mem_rd  out  1  memory read strobe.
- ir_i_half  out  8  byte to IR half input.
- ir_funsel  out  2  IR function select: 00 clear, 01 load, 10 decrement, 11 increment.
- ir_e  out  1  IR enable.
- ir_l_h  out  1  IR half select: 0 low, 1 high.
- pc_out  out  ADDR_W  current PC.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the instruction is complete in the IR.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE, PC = RESET_PC.
  - mem_rd, ir_e, busy and done are 0.
  - ir_funsel = 00, ir_l_h = 0, ir_i_half = 0.
  - Wait counter = 0.
- Reset mid-fetch: abort to IDLE on the next edge. ir_e is forced 0 in that cycle, so IR contents are left untouched.
- States: IDLE, RD_LO, WAIT_LO, LD_LO, RD_HI, WAIT_HI, LD_HI, DONE.
- Outputs are Moore-decoded from state, except ir_i_half, which is combinational mem_data in LD_LO/LD_HI and 0 otherwise.
- IDLE:
  - start=1 -> RD_LO.
  - pc_load=1 -> PC <= pc_in.
  - start and pc_load together: the PC load takes effect and the fetch uses the new PC, because RD_LO reads the updated register.
- RD_LO / RD_HI:
  - mem_rd = 1, mem_addr = PC.
  - Next state is LD_x if MEM_LAT=1, otherwise WAIT_x.
- WAIT_x:
  - mem_rd = 0; counter counts MEM_LAT-1 cycles, then -> LD_x.
- LD_LO:
  - ir_e = 1, ir_funsel = 01, ir_l_h = 0, ir_i_half = mem_data.
  - PC <= PC+1, then -> RD_HI.
- LD_HI:
  - Same as LD_LO but ir_l_h = 1.
  - PC <= PC+1, then -> DONE.
- DONE: done = 1 for exactly one cycle, then -> IDLE.
- In every non-LD state, ir_e = 0 and ir_funsel = 00.
- Latency from the start-sampling edge to done high is 5 + 2*(MEM_LAT-1) cycles. The IR holds the new word from the cycle done is high.
- PC arithmetic: modulo 2^ADDR_W. With PC = 0xFFFF, the low byte is read at 0xFFFF and the high byte at 0x0000; PC ends at 0x0001.
- start or pc_load while busy: ignored, with no queuing.
- start held high continuously: back-to-back fetches; the next fetch begins one cycle after DONE (IDLE is visited for one cycle).
- busy = 1 from RD_LO through DONE inclusive.

Optional Feature:
- Macro: FETCH_CLR_EN.
- Defined:
  - Extra state CLR is inserted between IDLE and RD_LO.
  - In CLR: ir_e = 1, ir_funsel = 00, so the IR is zeroed before loading.
  - Latency +1 cycle.
  - A reset that arrives during CLR still aborts to IDLE.
- Not defined: no CLR state. The IR is never cleared by this block; both halves are overwritten by the loads.

Test Plan:
- Basic fetch: reset, PC=0, mem[0]=0xAA, mem[1]=0x33, MEM_LAT=1, pulse start.
  - ir_e/l_h show (1,0,data 0xAA), then (1,1,data 0x33).
  - done high 5 cycles after start is sampled; IR = 0x33AA; pc_out = 0x0002.
- Latency: MEM_LAT=3, pc_load pc_in=0x0010 with start in the same cycle, mem[0x10]=0xF0, mem[0x11]=0x01.
  - mem_addr shows 0x0010 and then 0x0011.
  - done 9 cycles after start; IR = 0x01F0; PC = 0x0012.
- Wrap-around: PC=0xFFFF, mem[0xFFFF]=0x55, mem[0]=0x66.
  - IR = 0x6655; pc_out = 0x0001.
- Busy guard: pulse start and pc_load with pc_in=0x1234 during WAIT_LO.
  - Both ignored; only one done pulse; final PC = start PC + 2.
- Reset mid-fetch: assert rst in LD_LO cycle.
  - Next cycle: state IDLE, ir_e=0, busy=0, done never pulses, PC = RESET_PC.
  - A subsequent start fetches from RESET_PC correctly.
- Back-to-back with FETCH_CLR_EN: start held high; mem[0..3] = 4C 4C 66 55.
  - Each fetch begins with one cycle of ir_e=1, ir_funsel=00.
  - done pulses 6 cycles after each start-sampling edge.
  - IR = 0x4C4C, then 0x5566.

Source files
------------

// File: rtl/ir_fetch_seq.sv
// Two-byte instruction fetch sequencer: reads low then high byte at PC and steers each into the IR half-load port.
// Optional macro FETCH_CLR_EN adds a CLR state that zeroes the IR before every fetch.
module ir_fetch_seq #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [7:0]        ir_i_half,
    output logic [1:0]        ir_funsel,
    output logic              ir_e,
    output logic              ir_l_h,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_LO,
        S_WAIT_LO,
        S_LD_LO,
        S_RD_HI,
        S_WAIT_HI,
        S_LD_HI,
        S_DONE
`ifdef FETCH_CLR_EN
        , S_CLR
`endif
    } state_t;

`ifdef FETCH_CLR_EN
    localparam state_t S_FIRST = S_CLR;
`else
    localparam state_t S_FIRST = S_RD_LO;
`endif

    // WAIT_x lasts MEM_LAT-1 cycles; the counter runs 0..MEM_LAT-2
    localparam logic [1:0] WAIT_LAST = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;
    localparam logic [1:0] FS_CLEAR  = 2'b00;
    localparam logic [1:0] FS_LOAD   = 2'b01;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pc_load) pc_d = pc_in;
                if (start)   state_d = S_FIRST;
            end
`ifdef FETCH_CLR_EN
            S_CLR:   state_d = S_RD_LO;
`endif
            S_RD_LO: begin
                cnt_d   = '0;
                state_d = (MEM_LAT == 1) ? S_LD_LO : S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LD_LO;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_LD_LO: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_RD_HI;
            end
            S_RD_HI: begin
                cnt_d   = '0;
                state_d = (MEM_LAT == 1) ? S_LD_HI : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LD_HI;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_LD_HI: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = 1'b0;
        ir_e      = 1'b0;
        ir_funsel = FS_CLEAR;
        ir_l_h    = 1'b0;
        ir_i_half = 8'h00;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        case (state_q)
`ifdef FETCH_CLR_EN
            S_CLR:   ir_e = 1'b1;
`endif
            S_RD_LO, S_RD_HI: mem_rd = 1'b1;
            S_LD_LO: begin
                ir_e      = 1'b1;
                ir_funsel = FS_LOAD;
                ir_i_half = mem_data;
            end
            S_LD_HI: begin
                ir_e      = 1'b1;
                ir_funsel = FS_LOAD;
                ir_l_h    = 1'b1;
                ir_i_half = mem_data;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        // A reset landing on an IR-write cycle must leave the IR untouched
        if (rst) ir_e = 1'b0;
    end

    assign mem_addr = pc_q;
    assign pc_out   = pc_q;

endmodule
